// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - data-side bridge from the core to blockram, LED register and timer
// Optional timer block is compiled in when DMEM_BRIDGE_TIMER_EN is defined.
module dmem_bridge #(
  parameter int RAM_AW = 12,
  parameter int LED_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [31:0]      addr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic             ack,
  output logic             err,
  output logic             irq,
  output logic [31:0]      ram_addr,
  output logic [3:0]       ram_be,
  output logic [31:0]      ram_wdata,
  output logic             ram_we,
  input  logic [31:0]      ram_rdata,
  output logic [LED_W-1:0] led
);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_LED  = 2'd2;
  localparam logic [1:0] SEL_TMR  = 2'd3;

  localparam logic [29:0] LED_WADDR    = 30'h0400_0000;
  localparam logic [29:0] TCOUNT_WADDR = 30'h0400_0001;
  localparam logic [29:0] TCMP_WADDR   = 30'h0400_0002;
  localparam logic [29:0] TSTAT_WADDR  = 30'h0400_0003;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = lanes[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return res;
  endfunction

  logic             ram_hit;
  logic             led_hit;
  logic             cnt_hit;
  logic             cmp_hit;
  logic             stat_hit;
  logic             tmr_hit;
  logic             mapped;
  logic             wr;
  logic [1:0]       sel;
  logic [1:0]       sel_next;
  logic [31:0]      mmio_q;
  logic [31:0]      mmio_rd;
  logic [31:0]      tmr_rd;
  logic [LED_W-1:0] led_reg;

  assign ram_hit  = (addr[31:RAM_AW] == '0);
  assign led_hit  = (addr[31:2] == LED_WADDR);
  assign cnt_hit  = (addr[31:2] == TCOUNT_WADDR);
  assign cmp_hit  = (addr[31:2] == TCMP_WADDR);
  assign stat_hit = (addr[31:2] == TSTAT_WADDR);
  assign tmr_hit  = cnt_hit | cmp_hit | stat_hit;
  assign mapped   = ram_hit | led_hit | tmr_hit;
  assign wr       = req & we;

  // RAM side sees the core directly; only the write strobe is qualified.
  assign ram_addr  = addr;
  assign ram_be    = be;
  assign ram_wdata = wdata;
  assign ram_we    = req & we & ram_hit & ~reset;

`ifdef DMEM_BRIDGE_TIMER_EN
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        ten;
  logic        tflag;
  logic [31:0] cnt_next;
  logic [31:0] cmp_next;
  logic        en_next;
  logic        flag_next;
  logic        flag_clr;
  logic        match;

  always_comb begin
    cnt_next = ten ? tcount + 32'd1 : tcount;
    if (wr && cnt_hit)
      cnt_next = lane_merge(tcount, wdata, be);
    cmp_next = (wr && cmp_hit) ? lane_merge(tcmp, wdata, be) : tcmp;
    en_next  = (wr && stat_hit && be[0]) ? wdata[1] : ten;
    flag_clr = wr & stat_hit & be[0] & wdata[0];
    match    = ten & (cnt_next == cmp_next);
    // A match in the same cycle as a write-1-clear keeps the flag set.
    flag_next = match | (tflag & ~flag_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount <= 32'd0;
      tcmp   <= 32'hFFFF_FFFF;
      ten    <= 1'b0;
      tflag  <= 1'b0;
    end else begin
      tcount <= cnt_next;
      tcmp   <= cmp_next;
      ten    <= en_next;
      tflag  <= flag_next;
    end
  end

  always_comb begin
    tmr_rd = 32'd0;
    if (cnt_hit)
      tmr_rd = tcount;
    else if (cmp_hit)
      tmr_rd = tcmp;
    else if (stat_hit)
      tmr_rd = {30'd0, ten, tflag};
  end

  assign irq = tflag;
`else
  assign tmr_rd = 32'd0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    mmio_rd  = 32'd0;
    sel_next = SEL_NONE;
    if (req) begin
      if (ram_hit) begin
        sel_next = SEL_RAM;
      end else if (led_hit) begin
        sel_next = SEL_LED;
        mmio_rd  = {{(32-LED_W){1'b0}}, led_reg};
      end else if (tmr_hit) begin
        sel_next = SEL_TMR;
        mmio_rd  = tmr_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel     <= SEL_NONE;
      mmio_q  <= 32'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      led_reg <= '0;
    end else begin
      sel    <= sel_next;
      mmio_q <= mmio_rd;
      ack    <= req;
      err    <= req & ~mapped;
      if (wr && led_hit && be[0])
        led_reg <= wdata[LED_W-1:0];
    end
  end

  assign rdata = (sel == SEL_RAM) ? ram_rdata : mmio_q;
  assign led   = ~led_reg;

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the `franken_riscv` core's load/store port and `blockram`. It decodes each access into block RAM, an LED register driving the board LEDs, or a free-running timer with compare flag. Every access completes in exactly one cycle through a request/acknowledge pair. The bridge is the single consumer of the core's data-side outputs and the single producer of its `read_data`.

## Interface
Parameters:
- `RAM_AW`, 12: byte-address width of the RAM window (`0x0000_0000`..`2^RAM_AW-1`).
- `LED_W`, 6: LED count.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  core access request, one cycle per access.
- `addr`  in  32  byte address; `addr[1:0]` ignored (word-aligned).
- `be`  in  4  byte enables for writes.
- `wdata`  in  32  store data.
- `we`  in  1  1 = store, 0 = load (qualified by `req`).
- `rdata`  out  32  load data; valid when `ack`=1.
- `ack`  out  1  access complete.
- `err`  out  1  pulse with `ack` for an unmapped address.
- `irq`  out  1  timer match flag.
- `ram_addr`  out  32  to blockram.
- `ram_be`  out  4  to blockram.
- `ram_wdata`  out  32  to blockram.
- `ram_we`  out  1  to blockram.
- `ram_rdata`  in  32  from blockram, 1-cycle read latency.
- `led`  out  `LED_W`  board LEDs, active-low.

## Operation
Memory map (word addresses):
- RAM: `addr < 2^RAM_AW`.
- `0x1000_0000` LED: R/W; bits `[LED_W-1:0]`, written when `be[0]`=1.
- `0x1000_0004` TCOUNT: R/W.
- `0x1000_0008` TCMP: R/W.
- `0x1000_000C` TSTAT: bit0 = match flag (write 1 to clear); bit1 = timer enable (R/W).
- Any other address: unmapped.

Access rules:
- RAM: `ram_addr`, `ram_be` and `ram_wdata` mirror the core combinationally. `ram_we` = `req & we & ram_hit`.
- MMIO writes: TCOUNT and TCMP honour `be` per byte lane.
- Unmapped writes: ignored.
- Unmapped reads: return 0 with `err`=1.
- Registered state: sel (`RAM`/`LED`/`TMR`/`NONE`), the MMIO read word, and `ack`. `rdata` is muxed from `ram_rdata` or the registered MMIO word according to the registered sel.
- `led` = `~led_reg`.

Timer:
- TCOUNT increments by 1 every cycle while enable=1, wrapping `0xFFFF_FFFF` -> 0.
- A core write to TCOUNT in the same cycle as an increment takes priority.
- When enable=1 and the post-update TCOUNT equals TCMP, flag is set. Flag is sticky.
- `irq` = flag.
- Set and write-1-clear in the same cycle: set wins.

## Timing
- Request in cycle N -> `ack`=1 in N+1, with `rdata`/`err` valid in N+1.
- Requests may be issued every cycle (fully pipelined, one outstanding per cycle). No stall is ever generated.
- Writes take effect at the edge ending cycle N. A read issued in N+1 to the same register returns the new value.
- Reset values:
  - `ack`=0, `err`=0, `rdata`=0 (sel=`NONE`), `irq`=0.
  - `led`=all ones (LEDs off); LED reg=0.
  - TCOUNT=0, TCMP=`0xFFFF_FFFF`, enable=0, flag=0.
- Reset asserted while an access is in flight: that access's `ack` is suppressed; `ack`=0 in the cycle after reset. A RAM write already issued with `ram_we` is not undone.
- `ram_we` is never asserted during reset.

## Configuration
- `DMEM_BRIDGE_TIMER_EN` defined: timer registers, `irq` and the TSTAT behaviour above are present.
- Not defined: no timer logic. TCOUNT, TCMP and TSTAT decode as mapped, read 0 and ignore writes, `err`=0. `irq` is tied to 0.

## Test plan
- Reset, then `req`, `we`=1, `addr`=`0x1000_0000`, `wdata`=`0x2A`, `be`=`0001` -> `ack` next cycle; `led`=`6'b010101`; read-back returns `0x0000_002A`.
- Store `0xDEADBEEF` to RAM `0x10` with `be`=`1111`, then load `0x10` -> `ram_we` pulses once; load `ack` one cycle later with `rdata`=`0xDEADBEEF`.
- Load `0x2000_0000` -> `ack`=1, `err`=1, `rdata`=0. Back-to-back with a RAM load -> second `ack` has `err`=0.
- Timer (macro on): TCMP=5, enable=1 with TCOUNT=0 -> flag and `irq` rise the cycle TCOUNT becomes 5. Write TSTAT=`0x3` -> flag clears, enable stays 1.
- TCOUNT=`0xFFFF_FFFE`, enable=1 -> TCOUNT reads `0xFFFF_FFFF` then 0 on consecutive cycles. A write of 7 coinciding with an increment yields 7.
- Macro off: write TCMP=5 then read it -> 0. `irq` stays 0 for 100 cycles.
